// File: rtl/seq_datapath_pkg.sv
// Shared opcode, shift, state and status-bit definitions for seq_datapath.
package seq_datapath_pkg;

  localparam logic [2:0] OpMovi = 3'b000;
  localparam logic [2:0] OpMov  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpCmp  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpMvn  = 3'b101;

  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShLsl1 = 2'b01;
  localparam logic [1:0] ShLsr1 = 2'b10;
  localparam logic [1:0] ShAsr1 = 2'b11;

  localparam int unsigned StatusV = 2;
  localparam int unsigned StatusN = 1;
  localparam int unsigned StatusZ = 0;

  typedef enum logic [2:0] {StIdle, StRa, StRb, StEx, StWb} state_e;

  // 110 and 111 are reserved.
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/seq_datapath_regfile_p.sv
// Register file: one write port, combinational source and debug read ports, sync clear.
module regfile_p #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic [RW-1:0]    dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata     = mem_q[raddr];
  assign dbg_rdata = mem_q[dbg_raddr];

endmodule

// File: rtl/seq_datapath.sv
// Self-sequencing register-file/shifter/ALU datapath: one op per handshake, one-cycle response.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [RW-1:0]    req_rd,
  input  logic [RW-1:0]    req_rn,
  input  logic [RW-1:0]    req_rm,
  input  logic [1:0]       req_shift,
  input  logic [WIDTH-1:0] req_imm,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       status,
  input  logic [RW-1:0]    dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata
);

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [1:0]       shift_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       status_q;
  logic             rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             rf_we;
  logic [RW-1:0]    src_raddr;
  logic [WIDTH-1:0] src_rdata;
  logic [WIDTH-1:0] sh_b, alu_res;
  logic [2:0]       flags;

  regfile_p #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (c_q),
    .raddr    (src_raddr),
    .rdata    (src_rdata),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == OpMovi || op_reserved(req_op))   state_d = StWb;
          else if (req_op == OpMov || req_op == OpMvn)   state_d = StRb;
          else                                           state_d = StRa;
        end
      end
      StRa:    state_d = StRb;
      StRb:    state_d = StEx;
      StEx:    state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    src_raddr = (state_q == StRa) ? rn_q : rm_q;
    rf_we     = (state_q == StWb) && (op_q != OpCmp) && !op_reserved(op_q);
  end

  always_comb begin
    unique case (shift_q)
      ShLsl1:  sh_b = {b_q[WIDTH-2:0], 1'b0};
      ShLsr1:  sh_b = {1'b0, b_q[WIDTH-1:1]};
      ShAsr1:  sh_b = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: sh_b = b_q;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      OpMov:   alu_res = sh_b;
      OpAdd:   alu_res = a_q + sh_b;
      OpCmp:   alu_res = a_q - sh_b;
      OpAnd:   alu_res = a_q & sh_b;
      OpMvn:   alu_res = ~sh_b;
      default: alu_res = '0;
    endcase
    flags          = '0;
    flags[StatusZ] = (alu_res == '0);
    flags[StatusN] = alu_res[WIDTH-1];
    // Subtraction overflow: operand signs differ and result sign left A's.
    flags[StatusV] = (a_q[WIDTH-1] != sh_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= OpMovi;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      shift_q     <= ShNone;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            rd_q    <= req_rd;
            rn_q    <= req_rn;
            rm_q    <= req_rm;
            shift_q <= req_shift;
            a_q     <= '0;
            if (req_op == OpMovi) c_q <= req_imm;
          end
        end
        StRa: a_q <= src_rdata;
        StRb: b_q <= src_rdata;
        StEx: begin
          c_q <= alu_res;
          if (op_q == OpCmp) status_q <= flags;
        end
        StWb: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= op_reserved(op_q);
          rsp_data_q  <= op_reserved(op_q) ? '0 : c_q;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign status    = status_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: driver pushes model results, monitor checks responses.
module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [2:0]  req_rd, req_rn, req_rm;
  logic [1:0]  req_shift;
  logic [15:0] req_imm;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  status;
  logic [2:0]  dbg_raddr;
  logic [15:0] dbg_rdata;

  seq_datapath #(.WIDTH(16), .NREGS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_rd   (req_rd),
    .req_rn   (req_rn),
    .req_rm   (req_rm),
    .req_shift(req_shift),
    .req_imm  (req_imm),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .status   (status),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    logic [2:0]  st;
    longint      t_acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mregs[8];
  logic [2:0]  mstat;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd1:    return v << 1;
      2'd2:    return v >> 1;
      2'd3:    return 16'($signed(v) >>> 1);
      default: return v;
    endcase
  endfunction

  // Reference: apply the op to the architectural state in program order.
  task automatic model(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] imm,
                       output exp_t e);
    logic [15:0] a, s, r;
    a = mregs[rn];
    s = shf(mregs[rm], sh);
    r = 16'h0;
    e.err = 1'b0;
    case (op)
      3'd0: begin r = imm;    e.lat = 1; end
      3'd1: begin r = s;      e.lat = 3; end
      3'd2: begin r = a + s;  e.lat = 4; end
      3'd3: begin
        r = a - s; e.lat = 4;
        mstat = {(a[15] != s[15]) && (r[15] != a[15]), r[15], r == 16'h0};
      end
      3'd4: begin r = a & s;  e.lat = 4; end
      3'd5: begin r = ~s;     e.lat = 3; end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    if (op != 3'd3 && op < 3'd6) mregs[rd] = r;
    e.data = r;
    e.st   = mstat;
  endtask

  // Monitor: pops one expectation per response; otherwise checks ready is low while busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
          check("status", status, e.st);
          check("latency", ($time - e.t_acc - 5) / 10, e.lat);
          check("ready_in_rsp", req_ready, 1);
        end
      end else if (sb.size() != 0) begin
        check("ready_busy", req_ready, 0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic [15:0] imm,
                       input bit push, input bit hold);
    exp_t e;
    int   n;
    @(negedge clk);
    req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_shift = sh; req_imm = imm;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (push) model(op, rd, rn, rm, sh, imm, e);
    @(posedge clk);
    e.t_acc = $time;
    if (push) sb.push_back(e);
    if (!hold) begin
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < 50);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #1 check(name, dbg_rdata, mregs[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mstat = 3'b000;
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_status", status, 0);
    check_regs("reset_reg");
  endtask

  initial begin
    req_valid = 1'b0; req_op = '0; req_rd = '0; req_rn = '0; req_rm = '0;
    req_shift = '0; req_imm = '0; dbg_raddr = '0;
    do_reset();

    issue(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'd7, 1, 0);
    issue(3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'd2, 1, 0);
    issue(3'd2, 3'd2, 3'd1, 3'd0, 2'd1, 16'd0, 1, 0);
    wait_idle();
    dbg_raddr = 3'd2;
    #1 check("dbg_r2_16", dbg_rdata, 16'd16);
    check("status_after_add", status, 3'b000);

    issue(3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'h8000, 1, 0);
    issue(3'd0, 3'd4, 3'd0, 3'd0, 2'd0, 16'h0001, 1, 0);
    issue(3'd3, 3'd0, 3'd3, 3'd4, 2'd0, 16'h0, 1, 0);
    wait_idle();
    check("cmp_status_v", status, 3'b100);
    issue(3'd3, 3'd0, 3'd4, 3'd4, 2'd0, 16'h0, 1, 0);
    wait_idle();
    check("cmp_status_z", status, 3'b001);

    issue(3'd0, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFFF0, 1, 0);
    issue(3'd1, 3'd6, 3'd0, 3'd5, 2'd3, 16'h0, 1, 0);
    issue(3'd1, 3'd6, 3'd0, 3'd5, 2'd2, 16'h0, 1, 0);
    issue(3'd5, 3'd7, 3'd0, 3'd5, 2'd0, 16'h0, 1, 0);
    wait_idle();
    check_regs("regs_after_mov");

    // req_valid held across three ops; fields change while the DUT is busy.
    issue(3'd2, 3'd1, 3'd1, 3'd1, 2'd0, 16'h0, 1, 1);
    issue(3'd4, 3'd0, 3'd5, 3'd7, 2'd1, 16'h0, 1, 1);
    issue(3'd0, 3'd2, 3'd0, 3'd0, 2'd0, 16'h1234, 1, 0);
    wait_idle();
    check_regs("regs_after_hold");

    issue(3'd6, 3'd3, 3'd0, 3'd0, 2'd0, 16'h5555, 1, 0);
    issue(3'd7, 3'd4, 3'd0, 3'd0, 2'd0, 16'hAAAA, 1, 0);
    wait_idle();
    check_regs("regs_after_reserved");

    for (int k = 0; k < 60; k++) begin
      issue(3'($urandom_range(7)), 3'($urandom), 3'($urandom), 3'($urandom),
            2'($urandom), 16'($urandom), 1, 1'($urandom));
    end
    wait_idle();
    check_regs("regs_after_random");

    // Reset during EX of an ADD: no response, all state cleared.
    issue(3'd2, 3'd2, 3'd2, 3'd2, 2'd0, 16'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mstat = 3'b000;
    #1;
    check("midop_ready", req_ready, 1);
    check("midop_status", status, 0);
    repeat (6) @(negedge clk);
    #1 check_regs("midop_reg");

    issue(3'd0, 3'd2, 3'd0, 3'd0, 2'd0, 16'h00A5, 1, 0);
    wait_idle();
    check_regs("regs_after_midop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
